// File: rtl/seg7_ctrl_pkg.sv
// Shared constants for the seven-segment display controller: register map,
// CTRL layout, reset values and the packing of the decoder word.
package seg7_ctrl_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_SCROLL = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_BLANK_LSB     = 0;
  localparam int CTRL_BLINK_LSB     = 4;
  localparam int CTRL_SCROLL_EN_BIT = 8;
  localparam int CTRL_WIDTH         = 9;

  localparam logic [CTRL_WIDTH-1:0] CTRL_RESET = 9'h00F;
  localparam logic [31:0]           DIG_RESET  = 32'h000F_0000;

  localparam int DIG_NIB_LSB   = 0;
  localparam int DIG_BLANK_LSB = 16;

  // Field order mirrors the CTRL bit positions above.
  typedef struct packed {
    logic       scrollEn;
    logic [3:0] blink;
    logic [3:0] blank;
  } ctrl_t;

  function automatic logic [31:0] packDig(input logic [15:0] nibbles,
                                          input logic [3:0]  blank);
    logic [31:0] word;
    word = '0;
    word[DIG_NIB_LSB +: 16]  = nibbles;
    word[DIG_BLANK_LSB +: 4] = blank;
    return word;
  endfunction

endpackage

// File: rtl/seg7_tick_div.sv
// Free-running modulo-DIV counter with synchronous clear and enable; pulses
// wrap_o for the single cycle in which it rolls over from DIV-1 to 0.
module seg7_tick_div #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         atTop;

  assign atTop  = (cnt_q == W'(DIV - 1));
  // A clear in the same cycle as a rollover suppresses the pulse.
  assign wrap_o = en_i & atTop & ~clr_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = atTop ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_disp_ctrl.sv
// Wishbone slave owning the four-digit display word; a debug source with a
// hold-off timer overrides CPU data, blinking/blanking and two-page scrolling.
module seg7_disp_ctrl
  import seg7_ctrl_pkg::*;
#(
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCROLL_DIV = 50_000_000,
  parameter int DBG_HOLD   = 100_000_000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iCYC,
  input  logic        iSTB,
  input  logic        iWE,
  input  logic [3:0]  iADR,
  input  logic [31:0] iDAT,
  output logic [31:0] oDAT,
  output logic        oACK,
  input  logic        iDBG_VLD,
  input  logic [15:0] iDBG_VAL,
  output logic [31:0] oDIG
);

  localparam int HW = $clog2(DBG_HOLD + 2);

  logic [15:0]   data_q, data_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [31:0]   scroll_q, scroll_d;
  logic          ack_q;
  logic [31:0]   dat_q, dat_d;
  logic          phase_q, phase_d;
  logic          page_q, page_d;
  logic [15:0]   dbgVal_q, dbgVal_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          own_q, own_d;
  logic [31:0]   dig_q, dig_d;

  logic          req, wrEn, wrCtrl, wrScroll, scrollClr;
  logic          blinkWrap, scrollWrap;
  logic [1:0]    regSel;
  logic [31:0]   rdVal;
  logic [15:0]   nibbles;
  logic [3:0]    blank;
  logic          unusedAdr;

  assign unusedAdr = ^iADR[1:0];
  assign regSel    = iADR[3:2];
  // A strobe is serviced only while no ack is outstanding, so a held strobe
  // produces one ack every other cycle.
  assign req       = iCYC & iSTB & ~ack_q;
  assign wrEn      = req & iWE;
  assign wrCtrl    = wrEn & (regSel == REG_CTRL);
  assign wrScroll  = wrEn & (regSel == REG_SCROLL);
  assign scrollClr = wrScroll | (wrCtrl & ~iDAT[CTRL_SCROLL_EN_BIT]);

  seg7_tick_div #(.DIV(BLINK_DIV)) uBlinkDiv (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .clr_i  (1'b0),
    .en_i   (1'b1),
    .wrap_o (blinkWrap)
  );

  seg7_tick_div #(.DIV(SCROLL_DIV)) uScrollDiv (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .clr_i  (scrollClr),
    .en_i   (ctrl_q.scrollEn),
    .wrap_o (scrollWrap)
  );

  always_comb begin
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    scroll_d = scroll_q;
    if (wrEn) begin
      case (regSel)
        REG_DATA:   data_d   = iDAT[15:0];
        REG_CTRL:   ctrl_d   = ctrl_t'(iDAT[CTRL_WIDTH-1:0]);
        REG_SCROLL: scroll_d = iDAT;
        default:    ;
      endcase
    end
  end

  always_comb begin
    rdVal = '0;
    case (regSel)
      REG_DATA:   rdVal = {16'h0, data_q};
      REG_CTRL:   rdVal = {{(32 - CTRL_WIDTH){1'b0}}, ctrl_q};
      REG_SCROLL: rdVal = scroll_q;
      default:    rdVal = {29'h0, own_q, page_q, phase_q};
    endcase
    dat_d = (req & ~iWE) ? rdVal : 32'h0;
  end

  assign phase_d = phase_q ^ blinkWrap;
  assign page_d  = scrollClr ? 1'b0 : (page_q ^ scrollWrap);

  // Ownership is judged from the count before this cycle's decrement, so the
  // debug value survives DBG_HOLD cycles beyond the one that saw VLD fall.
  always_comb begin
    dbgVal_d = dbgVal_q;
    hold_d   = hold_q;
    own_d    = iDBG_VLD | (hold_q != '0);
    if (iDBG_VLD) begin
      dbgVal_d = iDBG_VAL;
      hold_d   = HW'(DBG_HOLD);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  always_comb begin
    nibbles = data_q;
    blank   = ctrl_q.blank | (ctrl_q.blink & {4{phase_q}});
    if (own_q) begin
      nibbles = dbgVal_q;
      blank   = 4'h0;
    end else if (ctrl_q.scrollEn) begin
      nibbles = page_q ? scroll_q[31:16] : scroll_q[15:0];
    end
    dig_d = packDig(nibbles, blank);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      data_q   <= '0;
      ctrl_q   <= ctrl_t'(CTRL_RESET);
      scroll_q <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      phase_q  <= 1'b0;
      page_q   <= 1'b0;
      dbgVal_q <= '0;
      hold_q   <= '0;
      own_q    <= 1'b0;
      dig_q    <= DIG_RESET;
    end else begin
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      scroll_q <= scroll_d;
      ack_q    <= req;
      dat_q    <= dat_d;
      phase_q  <= phase_d;
      page_q   <= page_d;
      dbgVal_q <= dbgVal_d;
      hold_q   <= hold_d;
      own_q    <= own_d;
      dig_q    <= dig_d;
    end
  end

  assign oACK = ack_q;
  assign oDAT = dat_q;
  assign oDIG = dig_q;

endmodule
